// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, width helpers and FSM state types for the RAM responder.
package axi4_pkg;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // One strobe bit per data byte.
  function automatic int unsigned strb_width(input int unsigned bus_width);
    return bus_width / 8;
  endfunction

  typedef enum logic [1:0] {
    WIdle = 2'd0,
    WData = 2'd1,
    WResp = 2'd2
  } wr_state_e;

  typedef enum logic {
    RIdle = 1'b0,
    RData = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_ram_responder_if.sv
// AXI4 write/read channel bundle between a memory-test master and the RAM responder.
interface axi4_ram_responder_if #(
  parameter int unsigned pAxi4BusWidth = 512,
  parameter int unsigned pAddrWidth    = 33,
  parameter int unsigned pIdWidth      = 6
);
  localparam int unsigned StrbW = axi4_pkg::strb_width(pAxi4BusWidth);

  logic [pAddrWidth-1:0]    i_awaddr;
  logic [pIdWidth-1:0]      i_awid;
  logic [7:0]               i_awlen;
  logic [1:0]               i_awburst;
  logic                     i_awvalid;
  logic                     o_awready;
  logic [pAxi4BusWidth-1:0] i_wdata;
  logic [StrbW-1:0]         i_wstrb;
  logic                     i_wlast;
  logic                     i_wvalid;
  logic                     o_wready;
  logic [pIdWidth-1:0]      o_bid;
  logic [1:0]               o_bresp;
  logic                     o_bvalid;
  logic                     i_bready;
  logic [pAddrWidth-1:0]    i_araddr;
  logic [pIdWidth-1:0]      i_arid;
  logic [7:0]               i_arlen;
  logic [1:0]               i_arburst;
  logic                     i_arvalid;
  logic                     o_arready;
  logic [pAxi4BusWidth-1:0] o_rdata;
  logic [pIdWidth-1:0]      o_rid;
  logic [1:0]               o_rresp;
  logic                     o_rlast;
  logic                     o_rvalid;
  logic                     i_rready;
  logic                     o_wlast_err;

  modport slave (
    input  i_awaddr, i_awid, i_awlen, i_awburst, i_awvalid,
    input  i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready,
    input  i_araddr, i_arid, i_arlen, i_arburst, i_arvalid, i_rready,
    output o_awready, o_wready, o_bid, o_bresp, o_bvalid,
    output o_arready, o_rdata, o_rid, o_rresp, o_rlast, o_rvalid, o_wlast_err
  );

  modport master (
    output i_awaddr, i_awid, i_awlen, i_awburst, i_awvalid,
    output i_wdata, i_wstrb, i_wlast, i_wvalid, i_bready,
    output i_araddr, i_arid, i_arlen, i_arburst, i_arvalid, i_rready,
    input  o_awready, o_wready, o_bid, o_bresp, o_bvalid,
    input  o_arready, o_rdata, o_rid, o_rresp, o_rlast, o_rvalid, o_wlast_err
  );

endinterface

// File: rtl/sdp_ram_be.sv
// Simple-dual-port RAM, byte write enables, registered read with enable, read-first.
module sdp_ram_be #(
  parameter int unsigned pDataWidth = 512,
  parameter int unsigned pDepth     = 1024,
  parameter int unsigned pAw        = $clog2(pDepth)
) (
  input  logic                    iCLK,
  input  logic                    we,
  input  logic [pAw-1:0]          waddr,
  input  logic [pDataWidth/8-1:0] wbe,
  input  logic [pDataWidth-1:0]   wdata,
  input  logic                    re,
  input  logic [pAw-1:0]          raddr,
  output logic [pDataWidth-1:0]   rdata
);

  logic [pDataWidth-1:0] mem [pDepth];

  // Byte-lane writes.
  always_ff @(posedge iCLK) begin
    if (we) begin
      for (int b = 0; b < int'(pDataWidth / 8); b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; output holds when re is low so a stalled beat stays put.
  always_ff @(posedge iCLK) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 slave backed by an internal RAM; independent single-outstanding write and read FSMs.
module axi4_ram_responder
  import axi4_pkg::*;
#(
  parameter int unsigned pAxi4BusWidth = 512,
  parameter int unsigned pAddrWidth    = 33,
  parameter int unsigned pIdWidth      = 6,
  parameter int unsigned pRamDepth     = 1024,
  parameter int unsigned pRamAw        = $clog2(pRamDepth)
) (
  input logic                 iCLK,
  input logic                 iRST,
  axi4_ram_responder_if.slave bus
);

  localparam int unsigned StrbW    = strb_width(pAxi4BusWidth);
  localparam int unsigned LaneBits = $clog2(StrbW);
  localparam int unsigned HiLsb    = LaneBits + pRamAw;

  // Write side state
  wr_state_e           w_state_q, w_state_d;
  logic [pRamAw-1:0]   w_idx_q, w_idx_d;
  logic                w_oor_q, w_oor_d;
  logic                w_fixed_q, w_fixed_d;
  logic [pIdWidth-1:0] w_id_q, w_id_d;
  logic [7:0]          w_len_q, w_len_d;
  logic [7:0]          w_cnt_q, w_cnt_d;
  logic                wlast_err_q, wlast_err_d;
  logic                awready, wready, aw_hs, w_hs, w_final, ram_we;

  // Read side state
  rd_state_e           r_state_q, r_state_d;
  logic [pRamAw-1:0]   r_idx_q, r_idx_d;
  logic                r_oor_q, r_oor_d;
  logic                r_fixed_q, r_fixed_d;
  logic [pIdWidth-1:0] r_id_q, r_id_d;
  logic [7:0]          r_len_q, r_len_d;
  logic [8:0]          r_issued_q, r_issued_d;
  logic                r_valid_q, r_valid_d;
  logic                r_last_q, r_last_d;
  logic                arready, ar_hs, r_can_adv, r_issue;
  logic [pAxi4BusWidth-1:0] ram_rdata;

  assign awready   = !iRST && (w_state_q == WIdle);
  assign wready    = !iRST && (w_state_q == WData);
  assign aw_hs     = awready && bus.i_awvalid;
  assign w_hs      = wready && bus.i_wvalid;
  assign w_final   = (w_cnt_q == w_len_q);
  assign arready   = !iRST && (r_state_q == RIdle);
  assign ar_hs     = arready && bus.i_arvalid;
  // The RAM output register doubles as the R skid: only reload it once the held beat is taken.
  assign r_can_adv = !r_valid_q || bus.i_rready;
  assign r_issue   = (r_state_q == RData) && r_can_adv && (r_issued_q <= {1'b0, r_len_q});

  // Write FSM next state: accept AW, count W beats against awlen, then issue B.
  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_oor_d     = w_oor_q;
    w_fixed_d   = w_fixed_q;
    w_id_d      = w_id_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    wlast_err_d = wlast_err_q;
    ram_we      = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          w_idx_d   = bus.i_awaddr[LaneBits +: pRamAw];
          w_oor_d   = |bus.i_awaddr[pAddrWidth-1:HiLsb];
          w_fixed_d = (bus.i_awburst == BurstFixed);
          w_id_d    = bus.i_awid;
          w_len_d   = bus.i_awlen;
          w_cnt_d   = '0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (w_hs) begin
          ram_we  = !w_oor_q;
          w_cnt_d = w_cnt_q + 8'd1;
          if (!w_fixed_q) w_idx_d = w_idx_q + pRamAw'(1);
          if (bus.i_wlast != w_final) wlast_err_d = 1'b1;
          if (w_final) w_state_d = WResp;
        end
      end
      WResp: begin
        if (bus.i_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read FSM next state: issue one RAM read per free output slot until arlen+1 beats are out.
  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_oor_d    = r_oor_q;
    r_fixed_d  = r_fixed_q;
    r_id_d     = r_id_q;
    r_len_d    = r_len_q;
    r_issued_d = r_issued_q;
    r_last_d   = r_last_q;
    r_valid_d  = r_valid_q;
    if (r_can_adv) r_valid_d = r_issue;
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_idx_d    = bus.i_araddr[LaneBits +: pRamAw];
          r_oor_d    = |bus.i_araddr[pAddrWidth-1:HiLsb];
          r_fixed_d  = (bus.i_arburst == BurstFixed);
          r_id_d     = bus.i_arid;
          r_len_d    = bus.i_arlen;
          r_issued_d = '0;
          r_state_d  = RData;
        end
      end
      RData: begin
        if (r_issue) begin
          r_issued_d = r_issued_q + 9'd1;
          r_last_d   = (r_issued_q == {1'b0, r_len_q});
          if (!r_fixed_q) r_idx_d = r_idx_q + pRamAw'(1);
        end
        if (r_valid_q && bus.i_rready && r_last_q) r_state_d = RIdle;
      end
    endcase
  end

  // State registers; reset drops any burst in flight.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      w_state_q   <= WIdle;
      w_idx_q     <= '0;
      w_oor_q     <= 1'b0;
      w_fixed_q   <= 1'b0;
      w_id_q      <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      wlast_err_q <= 1'b0;
      r_state_q   <= RIdle;
      r_idx_q     <= '0;
      r_oor_q     <= 1'b0;
      r_fixed_q   <= 1'b0;
      r_id_q      <= '0;
      r_len_q     <= '0;
      r_issued_q  <= '0;
      r_valid_q   <= 1'b0;
      r_last_q    <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_oor_q     <= w_oor_d;
      w_fixed_q   <= w_fixed_d;
      w_id_q      <= w_id_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      wlast_err_q <= wlast_err_d;
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_oor_q     <= r_oor_d;
      r_fixed_q   <= r_fixed_d;
      r_id_q      <= r_id_d;
      r_len_q     <= r_len_d;
      r_issued_q  <= r_issued_d;
      r_valid_q   <= r_valid_d;
      r_last_q    <= r_last_d;
    end
  end

  // Bus outputs, all forced low while reset is asserted.
  always_comb begin
    bus.o_awready   = awready;
    bus.o_wready    = wready;
    bus.o_bvalid    = !iRST && (w_state_q == WResp);
    bus.o_bid       = iRST ? '0 : w_id_q;
    bus.o_bresp     = (iRST || !w_oor_q) ? RespOkay : RespSlverr;
    bus.o_arready   = arready;
    bus.o_rvalid    = !iRST && r_valid_q;
    bus.o_rdata     = (iRST || r_oor_q) ? '0 : ram_rdata;
    bus.o_rid       = iRST ? '0 : r_id_q;
    bus.o_rresp     = (iRST || !r_oor_q) ? RespOkay : RespSlverr;
    bus.o_rlast     = !iRST && r_last_q;
    bus.o_wlast_err = !iRST && wlast_err_q;
  end

  sdp_ram_be #(
    .pDataWidth(pAxi4BusWidth),
    .pDepth    (pRamDepth),
    .pAw       (pRamAw)
  ) u_ram (
    .iCLK (iCLK),
    .we   (ram_we),
    .waddr(w_idx_q),
    .wbe  (bus.i_wstrb),
    .wdata(bus.i_wdata),
    .re   (r_issue),
    .raddr(r_idx_q),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Scoreboard bench for axi4_ram_responder: tasks push expected B/R responses from a word-array
// memory model; an independent monitor pops and compares on every B and R handshake.
module tb_axi4_ram_responder;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [511:0] data;
    logic [5:0]   id;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_ram_responder_if #(.pAxi4BusWidth(512), .pAddrWidth(33), .pIdWidth(6)) bus ();

  axi4_ram_responder #(
    .pAxi4BusWidth(512),
    .pAddrWidth   (33),
    .pIdWidth     (6),
    .pRamDepth    (1024)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  logic [511:0] mem_m [1024];
  b_exp_t       exp_b [$];
  r_exp_t       exp_r [$];
  b_exp_t       eb;
  r_exp_t       er;
  bit           exp_wlast_err = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;
  int           rmode = 0;   // 0: rready high, 1: pattern 1,0,0,1, 2: random
  int           cyc = 0;

  function automatic void check(input string name, input logic [511:0] act,
                                input logic [511:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endfunction

  function automatic void timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT, got 0 expected 1", name);
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Ready drivers for the response channels.
  initial begin
    bus.i_rready = 1'b0;
    bus.i_bready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rmode)
        0:       bus.i_rready = 1'b1;
        1:       bus.i_rready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: bus.i_rready = ($urandom_range(0, 1) == 1);
      endcase
      bus.i_bready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every handshake consumes one expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_bvalid && bus.i_bready) begin
        if (exp_b.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL b_unexpected: got bid %0h, expected no response", bus.o_bid);
        end else begin
          eb = exp_b.pop_front();
          check("bid", 512'(bus.o_bid), 512'(eb.id));
          check("bresp", 512'(bus.o_bresp), 512'(eb.resp));
        end
      end
      if (bus.o_rvalid && bus.i_rready) begin
        if (exp_r.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL r_unexpected: got rdata %0h, expected no beat", bus.o_rdata);
        end else begin
          er = exp_r.pop_front();
          check("rdata", bus.o_rdata, er.data);
          check("rid", 512'(bus.o_rid), 512'(er.id));
          check("rresp", 512'(bus.o_rresp), 512'(er.resp));
          check("rlast", 512'(bus.o_rlast), 512'(er.last));
        end
      end
    end
  end

  task automatic do_write(input longint unsigned addr, input logic [5:0] id, input int len,
                          input logic [1:0] burst, input int last_at, input int dmode,
                          input logic [63:0] strb, input bit rnd_strb);
    logic [511:0] d [16];
    logic [63:0]  s [16];
    int           base, idx, n;
    bit           oor;
    b_exp_t       e;
    base = int'((addr >> 6) % 1024);
    oor  = (addr >= 64'h1_0000);
    for (int b = 0; b <= len; b++) begin
      case (dmode)
        0:       d[b] = 512'(b);
        1:       d[b] = rand512();
        2:       d[b] = '0;
        default: d[b] = '1;
      endcase
      s[b] = rnd_strb ? {$urandom, $urandom} : strb;
      idx  = (burst == 2'b00) ? base : (base + b) % 1024;
      if (!oor) begin
        for (int k = 0; k < 64; k++) if (s[b][k]) mem_m[idx][k*8 +: 8] = d[b][k*8 +: 8];
      end
    end
    if (last_at != len) exp_wlast_err = 1'b1;
    e.id   = id;
    e.resp = oor ? 2'b10 : 2'b00;
    exp_b.push_back(e);
    @(posedge clk);
    #1;
    bus.i_awaddr  = 33'(addr);
    bus.i_awid    = id;
    bus.i_awlen   = 8'(len);
    bus.i_awburst = burst;
    bus.i_awvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_awready && n < 50);
    if (!bus.o_awready) timeout("aw_handshake");
    @(posedge clk);
    #1;
    bus.i_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.i_wdata  = d[b];
      bus.i_wstrb  = s[b];
      bus.i_wlast  = (b == last_at);
      bus.i_wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.o_wready && n < 50);
      if (!bus.o_wready) timeout("w_handshake");
      @(posedge clk);
      #1;
    end
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
    n = 0;
    while (exp_b.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_b.size() != 0) begin
      timeout("b_response");
      exp_b.delete();
    end
    check("wlast_err", 512'(bus.o_wlast_err), 512'(exp_wlast_err));
  endtask

  task automatic push_read(input longint unsigned addr, input logic [5:0] id, input int len,
                           input logic [1:0] burst);
    int     base, idx;
    bit     oor;
    r_exp_t e;
    base = int'((addr >> 6) % 1024);
    oor  = (addr >= 64'h1_0000);
    for (int b = 0; b <= len; b++) begin
      idx    = (burst == 2'b00) ? base : (base + b) % 1024;
      e.data = oor ? '0 : mem_m[idx];
      e.id   = id;
      e.resp = oor ? 2'b10 : 2'b00;
      e.last = (b == len);
      exp_r.push_back(e);
    end
  endtask

  task automatic ar_handshake(input longint unsigned addr, input logic [5:0] id, input int len,
                              input logic [1:0] burst);
    int n;
    @(posedge clk);
    #1;
    bus.i_araddr  = 33'(addr);
    bus.i_arid    = id;
    bus.i_arlen   = 8'(len);
    bus.i_arburst = burst;
    bus.i_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_arready && n < 50);
    if (!bus.o_arready) timeout("ar_handshake");
    @(posedge clk);
    #1;
    bus.i_arvalid = 1'b0;
  endtask

  task automatic do_read(input longint unsigned addr, input logic [5:0] id, input int len,
                         input logic [1:0] burst, input bit chk_lat);
    int n;
    push_read(addr, id, len, burst);
    ar_handshake(addr, id, len, burst);
    if (chk_lat) begin
      @(negedge clk);
      check("rvalid_lat1", 512'(bus.o_rvalid), 512'(0));
      @(negedge clk);
      check("rvalid_lat2", 512'(bus.o_rvalid), 512'(1));
    end
    n = 0;
    while (exp_r.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (exp_r.size() != 0) begin
      timeout("r_beats");
      exp_r.delete();
    end
    @(negedge clk);
    check("rvalid_after_last", 512'(bus.o_rvalid), 512'(0));
  endtask

  initial begin
    longint unsigned a;
    int              len;
    bus.i_awaddr = '0; bus.i_awid = '0; bus.i_awlen = '0; bus.i_awburst = '0;
    bus.i_awvalid = 1'b0; bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0;
    bus.i_wvalid = 1'b0; bus.i_araddr = '0; bus.i_arid = '0; bus.i_arlen = '0;
    bus.i_arburst = '0; bus.i_arvalid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 512'(bus.o_awready), 512'(0));
    check("rst_arready", 512'(bus.o_arready), 512'(0));
    check("rst_wready", 512'(bus.o_wready), 512'(0));
    check("rst_bvalid", 512'(bus.o_bvalid), 512'(0));
    check("rst_rvalid", 512'(bus.o_rvalid), 512'(0));
    check("rst_wlast_err", 512'(bus.o_wlast_err), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_rst", 512'(bus.o_awready), 512'(1));
    check("arready_after_rst", 512'(bus.o_arready), 512'(1));

    // Fill the whole RAM so every later read has a defined expectation.
    for (int w = 0; w < 1024; w += 16)
      do_write(longint'(w) << 6, 6'(w / 16), 15, 2'b01, 15, 1, '1, 1'b0);

    // 16-beat INCR of beat indices, read back.
    do_write(64'h0, 6'd0, 15, 2'b01, 15, 0, '1, 1'b0);
    do_read(64'h0, 6'd0, 15, 2'b01, 1'b1);

    // Single-byte strobe over zeros.
    do_write(64'h40, 6'd3, 0, 2'b01, 0, 2, '1, 1'b0);
    do_write(64'h40, 6'd4, 0, 2'b01, 0, 3, 64'h1, 1'b0);
    do_read(64'h40, 6'd5, 0, 2'b01, 1'b1);

    // Read under rready pattern 1,0,0,1.
    rmode = 1;
    do_read(64'h200, 6'd6, 7, 2'b01, 1'b1);
    rmode = 0;

    // Out-of-range write and read; in-range alias must be untouched.
    do_write(64'h1_0000_0140, 6'd7, 3, 2'b01, 3, 1, '1, 1'b0);
    do_read(64'h140, 6'd8, 3, 2'b01, 1'b0);
    do_read(64'h1_0000_0140, 6'd9, 3, 2'b01, 1'b0);

    // FIXED bursts
    do_write(64'h300, 6'd10, 3, 2'b00, 3, 1, '1, 1'b1);
    do_read(64'h300, 6'd11, 3, 2'b00, 1'b0);

    // Early wlast sets the sticky error but termination follows awlen.
    do_write(64'h400, 6'd12, 3, 2'b01, 2, 1, '1, 1'b0);
    do_read(64'h400, 6'd13, 3, 2'b01, 1'b0);

    // Reset in the middle of an 8-beat read.
    push_read(64'h0, 6'd14, 7, 2'b01);
    ar_handshake(64'h0, 6'd14, 7, 2'b01);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_r.delete();
    exp_wlast_err = 1'b0;
    @(negedge clk);
    check("rvalid_in_rst", 512'(bus.o_rvalid), 512'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rvalid_rst_next", 512'(bus.o_rvalid), 512'(0));
    check("arready_in_rst", 512'(bus.o_arready), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("arready_post_rst", 512'(bus.o_arready), 512'(1));
    check("wlast_err_post_rst", 512'(bus.o_wlast_err), 512'(0));
    do_read(64'h0, 6'd15, 7, 2'b01, 1'b1);

    // Randomised traffic against the model.
    rmode = 2;
    for (int t = 0; t < 60; t++) begin
      a = (longint'($urandom_range(0, 1023)) << 6) | longint'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a |= 64'(1) << $urandom_range(16, 32);
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1)
        do_write(a, 6'($urandom), len, 2'($urandom), len, 1, '0, 1'b1);
      else
        do_read(a, 6'($urandom), len, 2'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_ram_responder.md
Name: axi4_ram_responder

Overview:
- AXI4 slave that terminates the write and read channels driven by the team's AXI4 memory-test masters.
- Backs them with an internal simple-dual-port RAM.
- Used in simulation and on-chip loopback in place of the DDR controller, so master burst and handshake logic can be checked without DDR.
- Write and read sides are independent FSMs, each handling one outstanding transaction.

Parameters:
pAxi4BusWidth, 512, data width in bits; WSTRB width = pAxi4BusWidth/8
pAddrWidth, 33, AXI address width
pIdWidth, 6, AXI ID width
pRamDepth, 1024, RAM depth in bus words; must be a power of 2
pRamAw, $clog2(pRamDepth), RAM word-index width

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-high reset
i_awaddr  in  pAddrWidth  write start address
i_awid  in  pIdWidth  write ID
i_awlen  in  8  beats-1
i_awburst  in  2  00 FIXED, 01 INCR
i_awvalid  in  1  write address valid
o_awready  out  1  write address ready
i_wdata  in  pAxi4BusWidth  write data
i_wstrb  in  pAxi4BusWidth/8  byte enables
i_wlast  in  1  last write beat
i_wvalid  in  1  write data valid
o_wready  out  1  write data ready
o_bid  out  pIdWidth  response ID
o_bresp  out  2  00 OKAY, 10 SLVERR
o_bvalid  out  1  response valid
i_bready  in  1  response ready
i_araddr  in  pAddrWidth  read start address
i_arid  in  pIdWidth  read ID
i_arlen  in  8  beats-1
i_arburst  in  2  00 FIXED, 01 INCR
i_arvalid  in  1  read address valid
o_arready  out  1  read address ready
o_rdata  out  pAxi4BusWidth  read data
o_rid  out  pIdWidth  read ID
o_rresp  out  2  00 OKAY, 10 SLVERR
o_rlast  out  1  last read beat
o_rvalid  out  1  read data valid
i_rready  in  1  read data ready
o_wlast_err  out  1  sticky flag: WLAST mismatch seen

Behaviour:
Reset
- All outputs 0 during reset. Both FSMs enter their IDLE state.
- o_awready and o_arready assert the first cycle after iRST falls.
- Reset mid-burst aborts the burst immediately: no B or R completion is issued. RAM contents are not cleared.

Address mapping
- Word index = addr[log2(pAxi4BusWidth/8) +: pRamAw]. Low byte-lane bits are ignored; AxSIZE is treated as full bus width.
- Any higher address bit set marks the transaction out of range.
- INCR: index+1 per beat, wrapping modulo pRamDepth.
- FIXED: index constant for all beats.
- Burst type 10/11 is treated as INCR.

Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE
- W_IDLE: o_awready=1. On AW handshake, latch addr/id/len/range flag; o_awready=0; go to W_DATA.
- W_DATA: o_wready=1. Each W handshake writes the RAM with byte enables from i_wstrb; out-of-range writes are dropped. Beat counter increments.
- On beat count == awlen+1: go to W_RESP and drop o_wready.
- If i_wlast is not high exactly on the final beat, set o_wlast_err (sticky until reset). Termination still follows awlen.
- W_RESP: o_bvalid=1, o_bid=latched ID, o_bresp=10 if out of range, else 00. Hold until i_bready, then return to W_IDLE. o_awready rises the following cycle.
- W data arriving before AW is not accepted: o_wready=0 outside W_DATA.

Read FSM: R_IDLE -> R_DATA -> R_IDLE
- R_IDLE: o_arready=1. On AR handshake, latch fields; go to R_DATA.
- RAM read latency is 1 cycle. First o_rvalid appears 2 cycles after the AR handshake.
- Beats are back-to-back while i_rready=1.
- While o_rvalid=1 and i_rready=0, o_rdata/o_rlast/o_rresp/o_rid must hold stable. A 1-entry skid register or a RAM-read stall is required.
- o_rlast=1 only on beat arlen. After the final handshake, o_rvalid=0 next cycle and the FSM returns to R_IDLE.
- Out-of-range reads return data 0 with o_rresp=10 on every beat.
- arlen=0 gives a single beat with o_rlast=1.

Simultaneous events
- Read and write run concurrently.
- A same-address same-cycle write and read returns the old data (read-first).

Decomposition:
- Shared package axi4_pkg holds:
  - burst encodings FIXED=2'b00, INCR=2'b01
  - response codes OKAY=2'b00, SLVERR=2'b10
  - the bus-width/strobe-width relation
  - FSM state constants
- One sub-module, sdp_ram_be: simple-dual-port RAM with byte write enables and registered read, read-first. Keeps vendor BRAM inference isolated.

Test Plan:
- Reset, then AW addr 0x0 len 15 INCR with 16 beats of data=beat index and all strobes set -> B OKAY id 0. Then AR addr 0x0 len 15 -> 16 beats with data 0..15, rlast only on beat 15.
- Write word 0x40 with wstrb=0x...0001 and data all-ones over prior zeros -> readback shows only byte 0 = 0xFF.
- Read len 7 with i_rready toggled 1,0,0,1 -> no beat lost or duplicated; data stable while stalled; 8 beats total.
- Write with address bit 32 set -> B resp 10, RAM unchanged. Read with bit 32 set -> rdata 0, rresp 10 on every beat.
- Write len 3 with wlast asserted on beat 2 -> o_wlast_err=1, B still issued after 4 beats.
- iRST asserted in the middle of an 8-beat read -> o_rvalid=0 next cycle; o_arready=1 the first cycle after reset; the next read succeeds.
